// File: rtl/calcn_pkg.sv
// calcn shared definitions: command/response codes, port FSM states
// and width helpers used by the core and its arbiter.
package calcn_pkg;

  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_LSH = 4'd5;
  localparam logic [3:0] CMD_RSH = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_SUCC = 2'd1;
  localparam logic [1:0] RESP_INOF = 2'd2;
  localparam logic [1:0] RESP_IERR = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OPB,
    S_WAIT,
    S_RESP
  } state_t;

  function automatic int shamt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_valid_cmd(input logic [3:0] c);
    return (c == CMD_ADD) || (c == CMD_SUB) ||
           (c == CMD_LSH) || (c == CMD_RSH);
  endfunction

endpackage

// File: rtl/calcn_rr_arb.sv
// calcn round-robin arbiter: one-hot grant, pointer advances to
// grantee+1 after every grant.
module calcn_rr_arb
  import calcn_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx
);

  logic [IDX_W-1:0]     ptr;
  logic [NUM_PORTS-1:0] mask;
  logic [NUM_PORTS-1:0] hi;
  logic [NUM_PORTS-1:0] pick_src;
  logic                 vld;

  // Requests at or above the pointer win; otherwise wrap to the lowest.
  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      mask[i] = (i >= int'(ptr));
    end
    hi       = req & mask;
    pick_src = (|hi) ? hi : req;
    vld      = |req;
    grant_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pick_src[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
    grant = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      grant[i] = vld && (grant_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (vld) begin
      if (grant_idx == IDX_W'(NUM_PORTS - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/calcn_core.sv
// calcn multi-port calculator: per-port request FSMs sharing one ALU.
// Optional CALCN_OVF_CHECK_EN flags ADD carry-out and SUB underflow.
module calcn_core
  import calcn_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 32
) (
  input  logic                          c_clk,
  input  logic                          reset,
  input  logic [0:4*NUM_PORTS-1]        req_cmd_in,
  input  logic [0:DATA_W*NUM_PORTS-1]   req_data_in,
  output logic [0:2*NUM_PORTS-1]        out_resp,
  output logic [0:DATA_W*NUM_PORTS-1]   out_data
);

  localparam int IDX_W = idx_w(NUM_PORTS);
  localparam int SH_W  = shamt_w(DATA_W);

  state_t            st    [NUM_PORTS];
  logic [3:0]        cmd_q [NUM_PORTS];
  logic [DATA_W-1:0] a_q   [NUM_PORTS];
  logic [DATA_W-1:0] b_q   [NUM_PORTS];

  logic [NUM_PORTS-1:0] wait_req;
  logic [NUM_PORTS-1:0] grant;
  logic [IDX_W-1:0]     grant_idx;

  always_comb begin
    wait_req = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      wait_req[p] = (st[p] == S_WAIT);
    end
  end

  calcn_rr_arb #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .clk       (c_clk),
    .rst_n     (reset),
    .req       (wait_req),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  logic [3:0]        alu_cmd;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W:0]   add_w;
  logic [SH_W-1:0]   shamt;
  logic              ovf_add;
  logic              ovf_sub;
  logic [DATA_W-1:0] alu_data;
  logic [1:0]        alu_resp;

  assign alu_cmd = cmd_q[grant_idx];
  assign alu_a   = a_q[grant_idx];
  assign alu_b   = b_q[grant_idx];
  assign add_w   = {1'b0, alu_a} + {1'b0, alu_b};
  assign shamt   = alu_b[SH_W-1:0];

`ifdef CALCN_OVF_CHECK_EN
  assign ovf_add = add_w[DATA_W];
  assign ovf_sub = (alu_b > alu_a);
`else
  logic unused_carry;
  assign unused_carry = add_w[DATA_W];
  assign ovf_add = 1'b0;
  assign ovf_sub = 1'b0;
`endif

  always_comb begin
    alu_resp = RESP_SUCC;
    alu_data = '0;
    unique case (alu_cmd)
      CMD_ADD: begin
        if (ovf_add) alu_resp = RESP_INOF;
        else         alu_data = add_w[DATA_W-1:0];
      end
      CMD_SUB: begin
        if (ovf_sub) alu_resp = RESP_INOF;
        else         alu_data = alu_a - alu_b;
      end
      CMD_LSH: alu_data = alu_a << shamt;
      CMD_RSH: alu_data = alu_a >> shamt;
      default: alu_resp = RESP_INOF;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      out_resp <= '0;
      out_data <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        st[p]    <= S_IDLE;
        cmd_q[p] <= CMD_NOP;
        a_q[p]   <= '0;
        b_q[p]   <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        out_resp[2*p +: 2]           <= RESP_NONE;
        out_data[DATA_W*p +: DATA_W] <= '0;
        unique case (st[p])
          S_IDLE, S_RESP: begin
            if (req_cmd_in[4*p +: 4] != CMD_NOP) begin
              cmd_q[p] <= req_cmd_in[4*p +: 4];
              a_q[p]   <= req_data_in[DATA_W*p +: DATA_W];
              st[p]    <= S_OPB;
            end else begin
              st[p] <= S_IDLE;
            end
          end
          S_OPB: begin
            b_q[p] <= req_data_in[DATA_W*p +: DATA_W];
            if (is_valid_cmd(cmd_q[p])) begin
              st[p] <= S_WAIT;
            end else begin
              st[p]              <= S_RESP;
              out_resp[2*p +: 2] <= RESP_INOF;
            end
          end
          S_WAIT: begin
            if (grant[p]) begin
              st[p]                        <= S_RESP;
              out_resp[2*p +: 2]           <= alu_resp;
              out_data[DATA_W*p +: DATA_W] <= alu_data;
            end
          end
          default: st[p] <= S_IDLE;
        endcase
      end
    end
  end

endmodule
